// File: rtl/alu_wide_sequencer.sv
// Issue stage in front of a W-bit combinational ALU: runs 2W-bit operations as two
// W-bit beats (low word first, carry chained) or a single beat for narrow operations.
module alu_wide_sequencer #(
   parameter int unsigned W = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2*W-1:0]  in_opA,
   input  logic [2*W-1:0]  in_opB,
   input  logic [3:0]      in_S,
   input  logic            in_M,
   input  logic            in_Cin,
   input  logic            in_narrow,
   output logic [W-1:0]    alu_opA,
   output logic [W-1:0]    alu_opB,
   output logic [3:0]      alu_S,
   output logic            alu_M,
   output logic            alu_Cin,
   input  logic [W-1:0]    alu_DO,
   input  logic            alu_C,
   input  logic            alu_V,
   input  logic            alu_N,
   input  logic            alu_Z,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2*W-1:0]  out_DO,
   output logic            out_C,
   output logic            out_V,
   output logic            out_N,
   output logic            out_Z
);

   localparam int unsigned W2 = 2 * W;

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [W2-1:0]   opa_q;
   logic [W2-1:0]   opb_q;
   logic [3:0]      s_q;
   logic            m_q;
   logic            cin_q;
   logic            narrow_q;
   logic            carry_lo;
   logic            z_lo;
   logic            accept_c;

   // Ready is combinational so a held result can retire and a new op enter on one edge
   assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
   assign accept_c = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept_c) state_nxt = LO;
         LO:      state_nxt = narrow_q ? DONE : HI;
         HI:      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = in_valid ? LO : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      alu_opA = '0;
      alu_opB = '0;
      alu_S   = '0;
      alu_M   = 1'b0;
      alu_Cin = 1'b0;
      case (state)
         LO: begin
            alu_opA = opa_q[W-1:0];
            alu_opB = opb_q[W-1:0];
            alu_S   = s_q;
            alu_M   = m_q;
            alu_Cin = cin_q;
         end
         HI: begin
            alu_opA = opa_q[W2-1:W];
            alu_opB = opb_q[W2-1:W];
            alu_S   = s_q;
            alu_M   = m_q;
            alu_Cin = carry_lo;
         end
         default: ;
      endcase
   end

   // Operand capture and result assembly; out_valid tracks entry into DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opa_q     <= '0;
         opb_q     <= '0;
         s_q       <= '0;
         m_q       <= 1'b0;
         cin_q     <= 1'b0;
         narrow_q  <= 1'b0;
         carry_lo  <= 1'b0;
         z_lo      <= 1'b0;
         out_valid <= 1'b0;
         out_DO    <= '0;
         out_C     <= 1'b0;
         out_V     <= 1'b0;
         out_N     <= 1'b0;
         out_Z     <= 1'b0;
      end else begin
         out_valid <= (state_nxt == DONE);
         if (accept_c) begin
            opa_q    <= in_opA;
            opb_q    <= in_opB;
            s_q      <= in_S;
            m_q      <= in_M;
            cin_q    <= in_Cin;
            narrow_q <= in_narrow;
         end
         case (state)
            LO: begin
               out_DO[W-1:0] <= alu_DO;
               carry_lo      <= alu_C;
               z_lo          <= alu_Z;
               if (narrow_q) begin
                  out_DO[W2-1:W] <= '0;
                  out_C          <= alu_C;
                  out_V          <= alu_V;
                  out_N          <= alu_N;
                  out_Z          <= alu_Z;
               end
            end
            HI: begin
               out_DO[W2-1:W] <= alu_DO;
               out_C          <= alu_C;
               out_V          <= alu_V;
               out_N          <= alu_N;
               out_Z          <= z_lo & alu_Z;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Bench for alu_wide_sequencer: a behavioural 32-bit ALU closes the loop and a
// 64-bit arithmetic reference model predicts every result and flag set.
module tb_alu_wide_sequencer;

   localparam logic [3:0] S_ADD = 4'b1001;
   localparam logic [3:0] S_SUB = 4'b0110;
   localparam logic [3:0] S_AND = 4'b1011;
   localparam logic [3:0] S_OR  = 4'b1110;
   localparam logic [3:0] S_XOR = 4'b0110;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_opA = '0;
   logic [63:0] in_opB = '0;
   logic [3:0]  in_S = '0;
   logic        in_M = 1'b0;
   logic        in_Cin = 1'b0;
   logic        in_narrow = 1'b0;
   logic [31:0] alu_opA;
   logic [31:0] alu_opB;
   logic [3:0]  alu_S;
   logic        alu_M;
   logic        alu_Cin;
   logic [31:0] alu_DO;
   logic        alu_C;
   logic        alu_V;
   logic        alu_N;
   logic        alu_Z;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_DO;
   logic        out_C;
   logic        out_V;
   logic        out_N;
   logic        out_Z;

   int checks = 0;
   int failures = 0;

   alu_wide_sequencer #(.W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opA(in_opA), .in_opB(in_opB), .in_S(in_S), .in_M(in_M),
      .in_Cin(in_Cin), .in_narrow(in_narrow),
      .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_S(alu_S), .alu_M(alu_M),
      .alu_Cin(alu_Cin), .alu_DO(alu_DO), .alu_C(alu_C), .alu_V(alu_V),
      .alu_N(alu_N), .alu_Z(alu_Z),
      .out_valid(out_valid), .out_ready(out_ready), .out_DO(out_DO),
      .out_C(out_C), .out_V(out_V), .out_N(out_N), .out_Z(out_Z)
   );

   always #5 clk = ~clk;

   // Behavioural stand-in for the 32-bit ALU (subset of modes used here)
   logic [32:0] alu_sum;
   logic [31:0] alu_bb;
   always_comb begin
      alu_DO  = '0;
      alu_C   = 1'b0;
      alu_V   = 1'b0;
      alu_bb  = '0;
      alu_sum = '0;
      if (alu_M) begin
         case (alu_S)
            S_AND:   alu_DO = alu_opA & alu_opB;
            S_OR:    alu_DO = alu_opA | alu_opB;
            S_XOR:   alu_DO = alu_opA ^ alu_opB;
            default: alu_DO = '0;
         endcase
      end else if (alu_S == S_ADD || alu_S == S_SUB) begin
         alu_bb  = (alu_S == S_SUB) ? ~alu_opB : alu_opB;
         alu_sum = {1'b0, alu_opA} + {1'b0, alu_bb} + 33'(alu_Cin);
         alu_DO  = alu_sum[31:0];
         alu_C   = alu_sum[32];
         alu_V   = (alu_opA[31] == alu_bb[31]) && (alu_DO[31] != alu_opA[31]);
      end
      alu_N = alu_DO[31];
      alu_Z = (alu_DO == 32'd0);
   end

   // Whole-operation reference: one 64-bit (or 32-bit) computation, no word splitting
   function automatic void ref_op(input logic [63:0] a, input logic [63:0] b,
                                  input logic [3:0] s, input logic m, input logic cin,
                                  input logic nar, output logic [63:0] r,
                                  output logic c, output logic v, output logic n,
                                  output logic z);
      logic [64:0] sum;
      logic [63:0] bb;
      c = 1'b0;
      v = 1'b0;
      if (m) begin
         case (s)
            S_AND:   r = a & b;
            S_OR:    r = a | b;
            S_XOR:   r = a ^ b;
            default: r = '0;
         endcase
         if (nar) r[63:32] = '0;
      end else begin
         bb = (s == S_SUB) ? ~b : b;
         if (nar) begin
            sum = {33'd0, a[31:0]} + {33'd0, bb[31:0]} + 65'(cin);
            r   = {32'd0, sum[31:0]};
            c   = sum[32];
            v   = (a[31] == bb[31]) && (r[31] != a[31]);
         end else begin
            sum = {1'b0, a} + {1'b0, bb} + 65'(cin);
            r   = sum[63:0];
            c   = sum[64];
            v   = (a[63] == bb[63]) && (r[63] != a[63]);
         end
      end
      n = nar ? r[31] : r[63];
      z = (r == 64'd0);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [3:0] s,
                        input logic m, input logic cin, input logic nar);
      in_opA = a; in_opB = b; in_S = s; in_M = m; in_Cin = cin; in_narrow = nar;
   endtask

   task automatic check_result(input string tag, input logic [63:0] a, input logic [63:0] b,
                               input logic [3:0] s, input logic m, input logic cin,
                               input logic nar);
      logic [63:0] r;
      logic c, v, n, z;
      ref_op(a, b, s, m, cin, nar, r, c, v, n, z);
      check({tag, ".valid"}, 64'(out_valid), 64'd1);
      check({tag, ".DO"}, out_DO, r);
      check({tag, ".CVNZ"}, 64'({out_C, out_V, out_N, out_Z}), 64'({c, v, n, z}));
   endtask

   // One full transaction with latency and ALU-drive checks; caller is at a negedge in IDLE
   task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] s, input logic m, input logic cin,
                         input logic nar);
      int n = 0;
      drive(a, b, s, m, cin, nar);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      drive({$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom));
      @(negedge clk);
      check({tag, ".lo_valid"}, 64'(out_valid), 64'd0);
      check({tag, ".lo_drive"}, {alu_opA, 31'd0, alu_Cin}, {a[31:0], 31'd0, cin});
      if (!nar) begin
         @(negedge clk);
         check({tag, ".hi_valid"}, 64'(out_valid), 64'd0);
         check({tag, ".hi_drive"}, {alu_opA, alu_opB}, {a[63:32], b[63:32]});
      end
      @(negedge clk);
      check_result(tag, a, b, s, m, cin, nar);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, ".retire"}, 64'(out_valid), 64'd0);
   endtask

   logic [63:0] ra, rb, pa, pb;
   logic [3:0]  rs;
   logic        rm, rc, rn;

   initial begin
      // Reset state
      #12;
      check("rst.valid", 64'(out_valid), 64'd0);
      check("rst.DO", out_DO, 64'd0);
      check("rst.flags", 64'({out_C, out_V, out_N, out_Z}), 64'd0);
      check("rst.in_ready", 64'(in_ready), 64'd1);
      check("rst.alu_drive", {alu_opA, alu_opB}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases
      run_op("add_carry", 64'h0000_0000_FFFF_FFFF, 64'd1, S_ADD, 1'b0, 1'b0, 1'b0);
      run_op("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, S_ADD, 1'b0, 1'b0, 1'b0);
      run_op("add_lozero", 64'h0000_0001_FFFF_FFFF, 64'd1, S_ADD, 1'b0, 1'b0, 1'b0);
      run_op("narrow_ovf", 64'hDEAD_BEEF_7FFF_FFFF, 64'hDEAD_BEEF_0000_0001, S_ADD, 1'b0,
             1'b0, 1'b1);
      run_op("and_logic", 64'hF0F0_F0F0_FFFF_FFFF, 64'hFFFF_0000_0000_0001, S_AND, 1'b1,
             1'b1, 1'b0);
      run_op("sub_borrow", 64'd0, 64'd1, S_SUB, 1'b0, 1'b1, 1'b0);

      // Backpressure: result held while a new op waits, then DONE->LO on one edge
      pa = {$urandom, $urandom};
      pb = {$urandom, $urandom};
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      drive(pa, pb, S_ADD, 1'b0, 1'b0, 1'b0);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      drive(ra, rb, S_XOR, 1'b1, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check_result("bp_first", pa, pb, S_ADD, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         check("bp.in_ready", 64'(in_ready), 64'd0);
         check_result("bp_hold", pa, pb, S_ADD, 1'b0, 1'b0, 1'b0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      check("bp.release_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      check("bp.retired", 64'(out_valid), 64'd0);
      check("bp.lo_drive", 64'(alu_opA), 64'(ra[31:0]));
      repeat (2) @(negedge clk);
      check_result("bp_second", ra, rb, S_XOR, 1'b1, 1'b0, 1'b0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // Reset while the high beat is in flight
      drive(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, S_ADD, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst.valid", 64'(out_valid), 64'd0);
      check("midrst.DO", out_DO, 64'd0);
      check("midrst.in_ready", 64'(in_ready), 64'd1);
      check("midrst.alu_drive", {alu_opA, alu_opB}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("midrst.no_pulse", 64'(out_valid), 64'd0);
      end
      run_op("post_rst", 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, S_ADD, 1'b0,
             1'b0, 1'b0);

      // Randomized operations against the reference model
      for (int i = 0; i < 40; i++) begin
         ra = {$urandom, $urandom};
         rb = ($urandom_range(0, 3) == 0) ? ~ra : {$urandom, $urandom};
         rc = 1'($urandom);
         rn = 1'($urandom);
         case ($urandom_range(0, 4))
            0:       begin rs = S_ADD; rm = 1'b0; end
            1:       begin rs = S_SUB; rm = 1'b0; end
            2:       begin rs = S_AND; rm = 1'b1; end
            3:       begin rs = S_OR;  rm = 1'b1; end
            default: begin rs = S_XOR; rm = 1'b1; end
         endcase
         run_op("rnd", ra, rb, rs, rm, rc, rn);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
